uart_xcvr: RTL and testbench

Parametrised full-duplex UART transceiver. It is the next generation of the team's fixed 8-bit, one-bit-per-clock TX/RX pair, adding:
- an internal baud divider
- configurable data width, parity and stop bits
- a valid/ready transmit handshake
- a mid-bit-sampling receiver with a synchroniser, false-start rejection and error flags

It sits between the core's byte-stream logic and the external serial pins.

---
 rtl/uart_xcvr.sv | 178 +++++++++++++++++
 tb/tb_uart_xcvr.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_xcvr.sv
// uart_xcvr: parametrised full-duplex UART with baud divider, parity, stop bits and RX error flags
module uart_xcvr #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              txd,
    output logic              tx_busy,
    input  logic              rxd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_parity_err,
    output logic              rx_frame_err,
    output logic              rx_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE = CW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_W - 1);
    localparam logic SLAST = (STOP_BITS == 2);
    localparam logic PEN = (PARITY_EN != 0);
    localparam logic ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT} rx_state_t;

    tx_state_t         t_state;
    logic [CW-1:0]     t_cnt;
    logic [BW-1:0]     t_bit;
    logic              t_stop;
    logic [DATA_W-1:0] t_sh;
    logic              t_par;

    rx_state_t         r_state;
    logic [CW-1:0]     r_cnt;
    logic [BW-1:0]     r_bit;
    logic [DATA_W-1:0] r_sh;
    logic              r_pe;
    logic              s1, rs;

    // TX: accept on valid&ready (also in the last stop cycle), then shift out start/data/parity/stop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_state  <= T_IDLE;
            t_cnt    <= '0;
            t_bit    <= '0;
            t_stop   <= 1'b0;
            t_sh     <= '0;
            t_par    <= 1'b0;
            txd      <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
        end else if (tx_valid && tx_ready) begin
            t_state  <= T_START;
            t_cnt    <= '0;
            t_sh     <= tx_data;
            t_par    <= (^tx_data) ^ ODD;
            txd      <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
        end else if (t_state != T_IDLE) begin
            t_cnt <= (t_cnt == LAST) ? '0 : t_cnt + CW'(1);
            if (t_state == T_STOP && t_cnt == PRE && t_stop == SLAST) tx_ready <= 1'b1;
            if (t_cnt == LAST) begin
                case (t_state)
                    T_START: begin
                        t_state <= T_DATA;
                        t_bit   <= '0;
                        txd     <= t_sh[0];
                    end
                    T_DATA: begin
                        if (t_bit == BLAST) begin
                            t_state <= PEN ? T_PARITY : T_STOP;
                            txd     <= PEN ? t_par : 1'b1;
                            t_stop  <= 1'b0;
                        end else begin
                            t_bit <= t_bit + BW'(1);
                            t_sh  <= t_sh >> 1;
                            txd   <= t_sh[1];
                        end
                    end
                    T_PARITY: begin
                        t_state <= T_STOP;
                        txd     <= 1'b1;
                        t_stop  <= 1'b0;
                    end
                    T_STOP: begin
                        if (t_stop == SLAST) begin
                            t_state <= T_IDLE;
                            tx_busy <= 1'b0;
                        end else t_stop <= 1'b1;
                    end
                    default: t_state <= T_IDLE;
                endcase
            end
        end
    end

    // RX: two-flop synchroniser, idles high so reset does not look like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b1;
            rs <= 1'b1;
        end else begin
            s1 <= rxd;
            rs <= s1;
        end
    end

    // RX: mid-bit sampling frame receiver with false-start rejection and error flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= R_IDLE;
            r_cnt         <= '0;
            r_bit         <= '0;
            r_sh          <= '0;
            r_pe          <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            r_cnt    <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
            case (r_state)
                R_IDLE: begin
                    if (!rs) begin
                        r_state <= R_START;
                        r_cnt   <= '0;
                    end
                end
                R_START: begin
                    if (r_cnt == HALF) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_pe    <= 1'b0;
                        r_state <= rs ? R_IDLE : R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_cnt == LAST) begin
                        r_sh  <= {rs, r_sh[DATA_W-1:1]};
                        r_bit <= r_bit + BW'(1);
                        if (r_bit == BLAST) r_state <= PEN ? R_PARITY : R_STOP;
                    end
                end
                R_PARITY: begin
                    if (r_cnt == LAST) begin
                        r_pe    <= rs ^ (^r_sh) ^ ODD;
                        r_state <= R_STOP;
                    end
                end
                R_STOP: begin
                    if (r_cnt == LAST) begin
                        rx_valid      <= 1'b1;
                        rx_data       <= r_sh;
                        rx_parity_err <= r_pe;
                        rx_frame_err  <= !rs;
                        r_state       <= rs ? R_IDLE : R_WAIT;
                    end
                end
                R_WAIT: if (rs) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign rx_busy = (r_state != R_IDLE);
endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: directed checks of uart_xcvr in three configurations (defaults, two stop bits, even parity)
module tb_uart_xcvr;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] tx_data [3];
    logic       tx_valid [3];
    logic       tx_ready [3];
    logic       txd [3];
    logic       tx_busy [3];
    logic       rxd [3];
    logic       drv [3];
    logic       lb [3];
    logic [7:0] rx_data [3];
    logic       rx_valid [3];
    logic       pe [3];
    logic       fe [3];
    logic       rx_busy [3];

    int tests = 0;
    int fails = 0;
    int nv [3] = '{0, 0, 0};
    logic [9:0] rec [3][16];

    // rxd is either looped back from txd or driven by the bench
    for (genvar g = 0; g < 3; g++) begin : g_lb
        assign rxd[g] = lb[g] ? txd[g] : drv[g];
    end

    uart_xcvr #(.CLKS_PER_BIT(4)) u0 (
        .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .txd(txd[0]), .tx_busy(tx_busy[0]), .rxd(rxd[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
        .rx_parity_err(pe[0]), .rx_frame_err(fe[0]), .rx_busy(rx_busy[0]));
    uart_xcvr #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .txd(txd[1]), .tx_busy(tx_busy[1]), .rxd(rxd[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
        .rx_parity_err(pe[1]), .rx_frame_err(fe[1]), .rx_busy(rx_busy[1]));
    uart_xcvr #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u2 (
        .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
        .txd(txd[2]), .tx_busy(tx_busy[2]), .rxd(rxd[2]), .rx_data(rx_data[2]), .rx_valid(rx_valid[2]),
        .rx_parity_err(pe[2]), .rx_frame_err(fe[2]), .rx_busy(rx_busy[2]));

    // record every rx_valid pulse as {parity_err, frame_err, data}
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rx_valid[i]) begin
                if (nv[i] < 16) rec[i][nv[i]] <= {pe[i], fe[i], rx_data[i]};
                nv[i] <= nv[i] + 1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // send one word through the handshake and check txd every cycle against the expected frame
    task automatic tx_frame(input int u, input logic [7:0] d, input logic [21:0] fr, input int nb);
        @(negedge clk);
        chk($sformatf("u%0d txd idle", u), 32'(txd[u]), 1);
        chk($sformatf("u%0d tx_ready idle", u), 32'(tx_ready[u]), 1);
        tx_data[u] = d;
        tx_valid[u] = 1'b1;
        @(posedge clk);
        #1 tx_valid[u] = 1'b0;
        chk($sformatf("u%0d tx_busy start", u), 32'(tx_busy[u]), 1);
        chk($sformatf("u%0d tx_ready start", u), 32'(tx_ready[u]), 0);
        for (int i = 0; i < nb; i++) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("u%0d txd bit%0d cyc%0d", u, i, k), 32'(txd[u]), 32'(fr[i]));
                @(posedge clk);
                #1;
            end
        end
        chk($sformatf("u%0d tx_busy end", u), 32'(tx_busy[u]), 0);
    endtask

    // wait (bounded) for rx_valid number idx and check the captured word and flags
    task automatic wait_rx(input int u, input int idx, input logic [7:0] d, input logic p, input logic f);
        int t = 0;
        while (nv[u] <= idx && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (nv[u] <= idx) chk($sformatf("u%0d rx_valid timeout", u), 32'(nv[u]), 32'(idx + 1));
        else begin
            chk($sformatf("u%0d rx_data #%0d", u, idx), 32'(rec[u][idx][7:0]), 32'(d));
            chk($sformatf("u%0d rx_frame_err #%0d", u, idx), 32'(rec[u][idx][8]), 32'(f));
            chk($sformatf("u%0d rx_parity_err #%0d", u, idx), 32'(rec[u][idx][9]), 32'(p));
        end
    endtask

    // drive nb serial bits on rxd, LSB first, 4 clocks each
    task automatic send_bits(input int u, input logic [21:0] b, input int nb);
        @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            drv[u] = b[i];
            repeat (4) @(negedge clk);
        end
    endtask

    typedef struct {
        int         u;
        logic [7:0] d;
        logic [21:0] fr;
        int         nb;
    } vec_t;

    vec_t vt [6];
    int b;
    logic [21:0] fr2;

    initial begin
        // frames written {stop.., data MSB..LSB, start}; txd sends bit 0 first
        vt[0] = '{0, 8'hA5, 22'b1_10100101_0, 10};
        vt[1] = '{0, 8'h00, 22'b1_00000000_0, 10};
        vt[2] = '{0, 8'hFF, 22'b1_11111111_0, 10};
        vt[3] = '{0, 8'h3C, 22'b1_00111100_0, 10};
        vt[4] = '{0, 8'h81, 22'b1_10000001_0, 10};
        vt[5] = '{2, 8'h07, 22'b1_1_00000111_0, 11};
        for (int i = 0; i < 3; i++) begin
            tx_data[i] = 8'h00;
            tx_valid[i] = 1'b0;
            drv[i] = 1'b1;
            lb[i] = 1'b1;
        end

        repeat (2) @(negedge clk);
        chk("reset txd", 32'(txd[0]), 1);
        chk("reset tx_ready", 32'(tx_ready[0]), 1);
        chk("reset tx_busy", 32'(tx_busy[0]), 0);
        chk("reset rx_valid", 32'(rx_valid[0]), 0);
        chk("reset rx_data", 32'(rx_data[0]), 0);
        chk("reset rx_parity_err", 32'(pe[0]), 0);
        chk("reset rx_frame_err", 32'(fe[0]), 0);
        chk("reset rx_busy", 32'(rx_busy[0]), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // loopback table
        foreach (vt[i]) begin
            b = nv[vt[i].u];
            tx_frame(vt[i].u, vt[i].d, vt[i].fr, vt[i].nb);
            wait_rx(vt[i].u, b, vt[i].d, 1'b0, 1'b0);
        end

        // back-to-back with two stop bits: ready for one cycle, next start right after stop
        b = nv[1];
        fr2 = 22'b11_11000011_0_11_00111100_0;
        @(negedge clk);
        tx_data[1] = 8'h3C;
        tx_valid[1] = 1'b1;
        @(posedge clk);
        #1 tx_data[1] = 8'hC3;
        for (int c = 0; c < 88; c++) begin
            chk($sformatf("b2b tx_ready cyc%0d", c), 32'(tx_ready[1]), 32'(c == 43 || c == 87));
            chk($sformatf("b2b txd cyc%0d", c), 32'(txd[1]), 32'(fr2[c / 4]));
            if (c == 44) tx_valid[1] = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("b2b tx_busy end", 32'(tx_busy[1]), 0);
        wait_rx(1, b, 8'h3C, 1'b0, 1'b0);
        wait_rx(1, b + 1, 8'hC3, 1'b0, 1'b0);

        // parity bit flipped on an otherwise good frame
        lb[2] = 1'b0;
        b = nv[2];
        send_bits(2, 22'b1_0_00000111_0, 11);
        wait_rx(2, b, 8'h07, 1'b1, 1'b0);

        // stop bit low, line held low, then a good frame
        lb[0] = 1'b0;
        repeat (4) @(negedge clk);
        b = nv[0];
        send_bits(0, 22'b0_01010101_0, 10);
        wait_rx(0, b, 8'h55, 1'b0, 1'b1);
        repeat (12) @(negedge clk);
        chk("no rx_valid while low", 32'(nv[0]), 32'(b + 1));
        chk("rx_busy while low", 32'(rx_busy[0]), 1);
        drv[0] = 1'b1;
        repeat (8) @(negedge clk);
        chk("no rx_valid after release", 32'(nv[0]), 32'(b + 1));
        send_bits(0, 22'b1_10010110_0, 10);
        wait_rx(0, b + 1, 8'h96, 1'b0, 1'b0);

        // one-cycle glitch is rejected as a false start
        repeat (8) @(negedge clk);
        b = nv[0];
        drv[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        drv[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("glitch rx_busy", 32'(rx_busy[0]), 0);
        repeat (20) @(posedge clk);
        #1 chk("glitch no rx_valid", 32'(nv[0]), 32'(b));

        // asynchronous reset in the middle of a loopback frame
        lb[0] = 1'b1;
        b = nv[0];
        @(negedge clk);
        tx_data[0] = 8'hA5;
        tx_valid[0] = 1'b1;
        @(posedge clk);
        #1 tx_valid[0] = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk("pre-reset tx_busy", 32'(tx_busy[0]), 1);
        chk("pre-reset rx_busy", 32'(rx_busy[0]), 1);
        rst = 1'b0;
        #1;
        chk("mid reset txd", 32'(txd[0]), 1);
        chk("mid reset tx_ready", 32'(tx_ready[0]), 1);
        chk("mid reset tx_busy", 32'(tx_busy[0]), 0);
        chk("mid reset rx_valid", 32'(rx_valid[0]), 0);
        chk("mid reset rx_busy", 32'(rx_busy[0]), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("no rx_valid from aborted frame", 32'(nv[0]), 32'(b));
        tx_frame(0, 8'h5A, 22'b1_01011010_0, 10);
        wait_rx(0, b, 8'h5A, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1 chk("single rx_valid after reset", 32'(nv[0]), 32'(b + 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
